// File: rtl/accumulator_cmd_sequencer.sv
// Command sequencer in front of a 4-bit accumulator: one command per handshake, repeated 1..2^CNT_W cycles.
// Optional macro ACCU_SEQ_SATURATE_EN aborts an ADD on overflow instead of letting it wrap.
`timescale 1ns/1ps
module accumulator_cmd_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [1:0]       i_OP,
  input  logic [3:0]       i_DATA,
  input  logic [CNT_W-1:0] i_REPEAT,
  output logic             o_ACC_EN,
  output logic [1:0]       o_ACC_C,
  output logic [3:0]       o_ACC_D,
  input  logic [3:0]       i_ACC_Q,
  input  logic             i_ACC_CARRY,
  output logic             o_DONE,
  output logic [3:0]       o_RESULT,
  output logic             o_CARRY,
  output logic             o_SAT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       acc_c_q, acc_c_d;
  logic [3:0]       acc_d_q, acc_d_d;
  logic             carry_acc_q, carry_acc_d;
  logic [3:0]       result_q, result_d;
  logic             carry_q, carry_d;

  // CLEAR reuses the load path with a zero operand.
  function automatic logic [1:0] ctrl_of(input op_t op);
    unique case (op)
      OP_ADD:  ctrl_of = 2'b00;
      OP_SUB:  ctrl_of = 2'b01;
      default: ctrl_of = 2'b10;
    endcase
  endfunction

`ifdef ACCU_SEQ_SATURATE_EN
  logic sat_acc_q, sat_acc_d;
  logic sat_q, sat_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_c_d     = acc_c_q;
    acc_d_d     = acc_d_q;
    carry_acc_d = carry_acc_q;
    result_d    = result_q;
    carry_d     = carry_q;
`ifdef ACCU_SEQ_SATURATE_EN
    sat_acc_d   = sat_acc_q;
    sat_d       = sat_q;
`endif
    o_READY     = 1'b0;
    o_ACC_EN    = 1'b0;
    o_DONE      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        o_READY = 1'b1;
        if (i_VALID) begin
          op_d        = op_t'(i_OP);
          cnt_d       = i_REPEAT;
          acc_c_d     = ctrl_of(op_t'(i_OP));
          acc_d_d     = (op_t'(i_OP) == OP_CLEAR) ? 4'h0 : i_DATA;
          carry_acc_d = 1'b0;
`ifdef ACCU_SEQ_SATURATE_EN
          sat_acc_d   = 1'b0;
`endif
          state_d     = S_EXEC;
        end
      end

      S_EXEC: begin
        o_ACC_EN = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
          carry_acc_d = carry_acc_q | i_ACC_CARRY;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
`ifdef ACCU_SEQ_SATURATE_EN
        // Suppress the overflowing ADD so the accumulator keeps its pre-overflow value.
        if ((op_q == OP_ADD) && i_ACC_CARRY) begin
          o_ACC_EN    = 1'b0;
          carry_acc_d = 1'b1;
          sat_acc_d   = 1'b1;
          state_d     = S_DONE;
        end
`endif
      end

      S_DONE: begin
        o_DONE   = 1'b1;
        result_d = i_ACC_Q;
        carry_d  = carry_acc_q;
`ifdef ACCU_SEQ_SATURATE_EN
        sat_d    = sat_acc_q;
`endif
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      acc_c_q     <= 2'b00;
      acc_d_q     <= 4'h0;
      carry_acc_q <= 1'b0;
      result_q    <= 4'h0;
      carry_q     <= 1'b0;
`ifdef ACCU_SEQ_SATURATE_EN
      sat_acc_q   <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_c_q     <= acc_c_d;
      acc_d_q     <= acc_d_d;
      carry_acc_q <= carry_acc_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
`ifdef ACCU_SEQ_SATURATE_EN
      sat_acc_q   <= sat_acc_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign o_ACC_C  = acc_c_q;
  assign o_ACC_D  = acc_d_q;
  assign o_RESULT = result_q;
  assign o_CARRY  = carry_q;
`ifdef ACCU_SEQ_SATURATE_EN
  assign o_SAT    = sat_q;
`else
  assign o_SAT    = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_cmd_sequencer.sv
// Directed bench for accumulator_cmd_sequencer with a behavioural 4-bit accumulator attached.
// Expected values follow ACCU_SEQ_SATURATE_EN when it is defined.
`timescale 1ns/1ps
module tb_accumulator_cmd_sequencer;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [3:0]       data;
  logic [CNT_W-1:0] rep;
  logic             acc_en;
  logic [1:0]       acc_c;
  logic [3:0]       acc_d;
  logic [3:0]       acc_q = 4'h0;
  logic             acc_carry;
  logic             done;
  logic [3:0]       result;
  logic             carry;
  logic             sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulator_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(valid), .o_READY(ready),
    .i_OP(op), .i_DATA(data), .i_REPEAT(rep),
    .o_ACC_EN(acc_en), .o_ACC_C(acc_c), .o_ACC_D(acc_d),
    .i_ACC_Q(acc_q), .i_ACC_CARRY(acc_carry),
    .o_DONE(done), .o_RESULT(result), .o_CARRY(carry), .o_SAT(sat)
  );

  // Accumulator: c1 loads D, else c0 selects Q-D (borrow as carry) or Q+D.
  logic [4:0] acc_sum;
  always_comb begin
    acc_sum = 5'd0;
    if (acc_c[1])      acc_sum = {1'b0, acc_d};
    else if (acc_c[0]) acc_sum = {1'b0, acc_q} - {1'b0, acc_d};
    else               acc_sum = {1'b0, acc_q} + {1'b0, acc_d};
  end
  assign acc_carry = acc_c[1] ? 1'b0 : acc_sum[4];
  always @(posedge clk) if (acc_en) acc_q <= acc_sum[3:0];

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] rep;
    logic [1:0] c;
    logic [3:0] d;
    logic [3:0] res;
    logic       car;
    logic       sat;
    int         en_cyc;
    int         done_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int en_cnt  = 0;
    int done_at = -1;
    wait_ready(tag);
    valid = 1'b1; op = v.op; data = v.data; rep = v.rep;
    @(posedge clk); #1;
    valid = 1'b0; op = ~v.op; data = ~v.data; rep = ~v.rep;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (acc_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check({tag, "_c"}, 32'(acc_c), 32'(v.c));
          check({tag, "_d"}, 32'(acc_d), 32'(v.d));
        end
      end
      if (done) begin
        done_at = n;
        break;
      end
      if (ready) break;
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(v.done_cyc));
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(v.en_cyc));
    @(negedge clk);
    check({tag, "_result"}, 32'(result), 32'(v.res));
    check({tag, "_carry"}, 32'(carry), 32'(v.car));
    check({tag, "_sat"}, 32'(sat), 32'(v.sat));
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_c_hold"}, 32'(acc_c), 32'(v.c));
  endtask

  initial begin
    int pulses;
    //            op     data  rep   c      d     res   car   sat  en done
    vecs[0]  = '{2'b11, 4'h5, 3'd0, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 1, 2};
    vecs[1]  = '{2'b10, 4'h3, 3'd0, 2'b10, 4'h3, 4'h3, 1'b0, 1'b0, 1, 2};
    vecs[2]  = '{2'b00, 4'h3, 3'd3, 2'b00, 4'h3, 4'hF, 1'b0, 1'b0, 4, 5};
    vecs[3]  = '{2'b10, 4'hE, 3'd0, 2'b10, 4'hE, 4'hE, 1'b0, 1'b0, 1, 2};
`ifdef ACCU_SEQ_SATURATE_EN
    vecs[4]  = '{2'b00, 4'h1, 3'd2, 2'b00, 4'h1, 4'hF, 1'b1, 1'b1, 1, 3};
`else
    vecs[4]  = '{2'b00, 4'h1, 3'd2, 2'b00, 4'h1, 4'h1, 1'b1, 1'b0, 3, 4};
`endif
    vecs[5]  = '{2'b10, 4'h9, 3'd0, 2'b10, 4'h9, 4'h9, 1'b0, 1'b0, 1, 2};
    vecs[6]  = '{2'b01, 4'h2, 3'd7, 2'b01, 4'h2, 4'h9, 1'b1, 1'b0, 8, 9};
    vecs[7]  = '{2'b11, 4'hA, 3'd0, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 1, 2};
`ifdef ACCU_SEQ_SATURATE_EN
    vecs[8]  = '{2'b00, 4'h5, 3'd7, 2'b00, 4'h5, 4'hF, 1'b1, 1'b1, 3, 5};
`else
    vecs[8]  = '{2'b00, 4'h5, 3'd7, 2'b00, 4'h5, 4'h8, 1'b1, 1'b0, 8, 9};
`endif
    vecs[9]  = '{2'b10, 4'h2, 3'd0, 2'b10, 4'h2, 4'h2, 1'b0, 1'b0, 1, 2};
    vecs[10] = '{2'b01, 4'h3, 3'd0, 2'b01, 4'h3, 4'hF, 1'b1, 1'b0, 1, 2};
    vecs[11] = '{2'b10, 4'h4, 3'd1, 2'b10, 4'h4, 4'h4, 1'b0, 1'b0, 2, 3};

    rst_n = 1'b0; valid = 1'b0; op = 2'b00; data = 4'h0; rep = '0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_en", 32'(acc_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_c", 32'(acc_c), 32'd0);
    check("rst_d", 32'(acc_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Valid held through EXEC/DONE: the held LOAD 7 is taken only once IDLE returns.
    wait_ready("b2b");
    valid = 1'b1; op = 2'b11; data = 4'h6; rep = 3'd0;
    @(posedge clk); #1;
    op = 2'b10; data = 4'h7; rep = 3'd1;
    @(negedge clk);
    check("b2b_c1_ready", 32'(ready), 32'd0);
    check("b2b_c1_d", 32'(acc_d), 32'd0);
    @(negedge clk);
    check("b2b_c2_ready", 32'(ready), 32'd0);
    check("b2b_c2_done", 32'(done), 32'd1);
    check("b2b_c2_d", 32'(acc_d), 32'd0);
    @(negedge clk);
    check("b2b_c3_ready", 32'(ready), 32'd1);
    check("b2b_c3_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("b2b_c4_en", 32'(acc_en), 32'd1);
    check("b2b_c4_c", 32'(acc_c), 32'd2);
    check("b2b_c4_d", 32'(acc_d), 32'd7);
    @(negedge clk);
    check("b2b_c5_en", 32'(acc_en), 32'd1);
    @(negedge clk);
    check("b2b_c6_done", 32'(done), 32'd1);
    @(negedge clk);
    check("b2b_c7_result", 32'(result), 32'd7);

    // Reset in the middle of ADD 5 x6 starting from 7.
    wait_ready("rst_mid");
    valid = 1'b1; op = 2'b00; data = 4'h5; rep = 3'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("rst_mid_en_before", 32'(acc_en), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_en", 32'(acc_en), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_carry", 32'(carry), 32'd0);
    check("rst_mid_sat", 32'(sat), 32'd0);
    check("rst_mid_c", 32'(acc_c), 32'd0);
    check("rst_mid_d", 32'(acc_d), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_acc_kept", 32'(acc_q), 32'hC);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_mid_no_done", 32'(pulses), 32'd0);
    run_vec(vecs[0], "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
